ldst_sequencer: RTL and testbench

//   Multi-cycle controller for LD/SD in the sequential RV64 core. Takes a fetched instruction plus

---
 rtl/ldst_sequencer.sv | 135 +++++++++++++
 tb/tb_ldst_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ldst_sequencer.sv
// LD/SD sequencer: decode imm, form rs1+imm, run one data-memory request/response, write back LD data.
// Latency start->done: SD 3 cycles, LD 5 cycles; mem_ready stretches REQ, mem_rvalid stretches WAIT up to TIMEOUT_CYCLES.
// Backpressure: start is ignored while busy. LDST_MISALIGN_TRAP_EN makes addr[2:0]!=0 a fault with no request.
module ldst_sequencer #(
   parameter int XLEN           = 64,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [31:0]     instruction,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic            busy,
   output logic            done,
   output logic            fault,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ready,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            rd_we,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] rd_data
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_REQ, S_WAIT, S_WB, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [6:0]      op_q;
   logic [2:0]      f3_q;
   logic [4:0]      rd_q;
   logic [11:0]     immhi_q;
   logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
   logic            is_sd_q, fault_q;
   logic [CW-1:0]   cnt_q;

   logic            is_ld, is_sd, bad_op, misalign, timeout;
   logic [11:0]     imm12;
   logic [XLEN-1:0] addr_sum;
   // register-index fields are unused: operands arrive already read as rs1_val/rs2_val
   logic            unused_rs_fields;

   assign unused_rs_fields = ^instruction[19:15];

   assign is_ld    = (op_q == 7'b0000011) && (f3_q == 3'b011);
   assign is_sd    = (op_q == 7'b0100011) && (f3_q == 3'b011);
   assign bad_op   = !(is_ld || is_sd);
   assign imm12    = is_sd ? {immhi_q[11:5], rd_q} : immhi_q;
   assign addr_sum = addr_q + {{(XLEN-12){imm12[11]}}, imm12};
   assign timeout  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`ifdef LDST_MISALIGN_TRAP_EN
   assign misalign = (addr_sum[2:0] != 3'b000);
`else
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_DECODE;
         S_DECODE: state_nxt = (bad_op || misalign) ? S_DONE : S_REQ;
         S_REQ:    if (mem_ready) state_nxt = is_sd_q ? S_DONE : S_WAIT;
         S_WAIT: begin
            if (mem_rvalid)   state_nxt = S_WB;
            else if (timeout) state_nxt = S_DONE;
         end
         S_WB:     state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != S_IDLE);
      done    = (state == S_DONE);
      fault   = (state == S_DONE) && fault_q;
      mem_req = (state == S_REQ);
      mem_we  = (state == S_REQ) && is_sd_q;
      rd_we   = (state == S_WB) && (rd_q != 5'd0);
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rd_addr   = rd_q;
   assign rd_data   = rdata_q;

   // addr_q holds rs1 until DECODE, then the effective address
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q    <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         immhi_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         is_sd_q <= 1'b0;
         fault_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               op_q    <= instruction[6:0];
               f3_q    <= instruction[14:12];
               rd_q    <= instruction[11:7];
               immhi_q <= instruction[31:20];
               addr_q  <= rs1_val;
               wdata_q <= rs2_val;
               fault_q <= 1'b0;
            end
            S_DECODE: begin
               addr_q  <= addr_sum;
               is_sd_q <= is_sd;
               fault_q <= bad_op || misalign;
            end
            S_REQ: cnt_q <= '0;
            S_WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (mem_rvalid)   rdata_q <= mem_rdata;
               else if (timeout) fault_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ldst_sequencer.sv
// Directed bench for ldst_sequencer: drives one instruction at a time through a small memory responder.
module tb_ldst_sequencer;
   logic        clk = 1'b0;
   logic        reset, start, mem_ready, mem_rvalid;
   logic [31:0] instruction;
   logic [63:0] rs1_val, rs2_val, mem_rdata;
   logic        busy, done, fault, mem_req, mem_we, rd_we;
   logic [63:0] mem_addr, mem_wdata, rd_data;
   logic [4:0]  rd_addr;

   int checks = 0;
   int failures = 0;

   localparam logic [31:0] LD_X5_8   = 32'h0080B283;
   localparam logic [31:0] SD_X2_M8  = 32'hFE21BC23;
   localparam logic [31:0] ADD_RTYPE = 32'h003100B3;
   localparam logic [31:0] LW_X5_8   = 32'h0080A283;
   localparam logic [31:0] LD_X0_0   = 32'h0000B003;
   localparam logic [31:0] LD_X6_16  = 32'h0100B303;
   localparam logic [31:0] LD_X7_3   = 32'h0030B383;

   ldst_sequencer #(.XLEN(64), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .start(start), .instruction(instruction),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .busy(busy), .done(done), .fault(fault),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   // results of the most recent run_op
   int          d_cyc, d_req, d_rdwe;
   bit          d_flt, d_stable, d_we;
   logic [63:0] d_addr, d_wdata, d_rdata;
   logic [4:0]  d_rdaddr;

   // Launches one instruction and plays memory. rdy_dly = REQ cycles refused before accept,
   // rv_dly = WAIT cycle index carrying rvalid (-1 never). Entered and left at a negedge.
   task automatic run_op(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2,
                         input int rdy_dly, input int rv_dly, input logic [63:0] rdat,
                         input bit hold, input bit noise);
      int cyc = 0;
      int widx = 0;
      bit accepted = 0;
      bit rv_given = 0;
      logic [63:0] f_addr = '0, f_wdata = '0;
      logic f_we = 1'b0;
      d_cyc = -1; d_flt = 0; d_req = 0; d_rdwe = 0; d_stable = 1;
      d_addr = '0; d_we = 0; d_wdata = '0; d_rdaddr = '0; d_rdata = '0;
      instruction = ins; rs1_val = r1; rs2_val = r2; start = 1'b1;
      mem_ready = noise; mem_rvalid = noise;
      while (cyc < 200 && d_cyc < 0) begin
         @(negedge clk);
         cyc++;
         if (busy && !done) begin
            if (!hold) start = 1'b0;
            rs1_val = ~r1; rs2_val = ~r2; instruction = 32'h0;
         end
         if (rd_we) begin
            d_rdwe++; d_rdaddr = rd_addr; d_rdata = rd_data;
         end
         if (mem_req) begin
            if (d_req == 0) begin
               f_addr = mem_addr; f_we = mem_we; f_wdata = mem_wdata;
            end else if (mem_addr !== f_addr || mem_we !== f_we || mem_wdata !== f_wdata) begin
               d_stable = 0;
            end
            mem_ready = (d_req >= rdy_dly);
            if (mem_ready) begin
               accepted = 1; d_addr = mem_addr; d_we = mem_we; d_wdata = mem_wdata;
            end
            d_req++;
         end else begin
            mem_ready = noise;
         end
         mem_rvalid = noise;
         mem_rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
         if (accepted && !rv_given && busy && !done && !mem_req) begin
            if (widx == rv_dly) begin
               mem_rvalid = 1'b1; mem_rdata = rdat; rv_given = 1;
            end
            widx++;
         end
         if (done) begin
            d_cyc = cyc; d_flt = fault; start = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, fault, mem_req, mem_we, rd_we} !== 6'b0) begin
         failures++; $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, fault, mem_req, mem_we, rd_we});
      end
      checks++;
      if ({mem_addr, mem_wdata, rd_addr, rd_data} !== '0) begin
         failures++; $display("FAIL reset_data: addr=%0h wdata=%0h rd=%0d rdata=%0h expected all 0", mem_addr, mem_wdata, rd_addr, rd_data);
      end
   endtask

   task automatic test_ld_basic();
      @(negedge clk);
      run_op(LD_X5_8, 64'h1000, 64'h0, 0, 1, 64'hDEAD_BEEF, 0, 0);
      checks++; if (d_cyc !== 6) begin failures++; $display("FAIL ld_done_cycle: got %0d expected 6", d_cyc); end
      checks++; if (d_flt !== 0) begin failures++; $display("FAIL ld_fault: got %0d expected 0", d_flt); end
      checks++; if (d_addr !== 64'h1008 || d_we !== 0) begin failures++; $display("FAIL ld_addr_we: got %0h/%0d expected 1008/0", d_addr, d_we); end
      checks++; if (d_rdwe !== 1) begin failures++; $display("FAIL ld_rdwe_count: got %0d expected 1", d_rdwe); end
      checks++; if (d_rdaddr !== 5'd5 || d_rdata !== 64'hDEAD_BEEF) begin failures++; $display("FAIL ld_writeback: got x%0d=%0h expected x5=deadbeef", d_rdaddr, d_rdata); end
   endtask

   task automatic test_sd_delayed();
      @(negedge clk);
      run_op(SD_X2_M8, 64'h2010, 64'h55, 3, -1, 64'h0, 0, 0);
      checks++; if (d_req !== 4) begin failures++; $display("FAIL sd_req_cycles: got %0d expected 4", d_req); end
      checks++; if (d_stable !== 1) begin failures++; $display("FAIL sd_req_stable: got %0d expected 1", d_stable); end
      checks++; if (d_addr !== 64'h2008 || d_we !== 1 || d_wdata !== 64'h55) begin failures++; $display("FAIL sd_accept: got %0h/%0d/%0h expected 2008/1/55", d_addr, d_we, d_wdata); end
      checks++; if (d_cyc !== 6 || d_flt !== 0) begin failures++; $display("FAIL sd_done: got cycle %0d fault %0d expected 6/0", d_cyc, d_flt); end
      checks++; if (d_rdwe !== 0) begin failures++; $display("FAIL sd_no_rdwe: got %0d expected 0", d_rdwe); end
   endtask

   task automatic test_illegal();
      @(negedge clk);
      run_op(ADD_RTYPE, 64'h1000, 64'h0, 0, -1, 64'h0, 0, 1);
      checks++; if (d_cyc !== 2 || d_flt !== 1) begin failures++; $display("FAIL rtype_fault: got cycle %0d fault %0d expected 2/1", d_cyc, d_flt); end
      checks++; if (d_req !== 0) begin failures++; $display("FAIL rtype_no_req: got %0d expected 0", d_req); end
      @(negedge clk);
      run_op(LW_X5_8, 64'h1000, 64'h0, 0, 0, 64'h0, 0, 0);
      checks++; if (d_cyc !== 2 || d_flt !== 1 || d_req !== 0) begin failures++; $display("FAIL lw_fault: got cycle %0d fault %0d req %0d expected 2/1/0", d_cyc, d_flt, d_req); end
   endtask

   task automatic test_timeout();
      @(negedge clk);
      run_op(LD_X5_8, 64'h1000, 64'h0, 0, -1, 64'h0, 0, 0);
      checks++; if (d_cyc !== 19 || d_flt !== 1) begin failures++; $display("FAIL timeout_fault: got cycle %0d fault %0d expected 19/1", d_cyc, d_flt); end
      checks++; if (d_rdwe !== 0) begin failures++; $display("FAIL timeout_no_rdwe: got %0d expected 0", d_rdwe); end
      @(negedge clk);
      run_op(LD_X5_8, 64'h1000, 64'h0, 0, 15, 64'h77, 0, 0);
      checks++; if (d_cyc !== 20 || d_flt !== 0 || d_rdata !== 64'h77) begin failures++; $display("FAIL timeout_last_cycle: got cycle %0d fault %0d data %0h expected 20/0/77", d_cyc, d_flt, d_rdata); end
   endtask

   task automatic test_x0_and_wrap();
      @(negedge clk);
      run_op(LD_X0_0, 64'h3000, 64'h0, 0, 0, 64'h1234, 0, 0);
      checks++; if (d_rdwe !== 0 || d_cyc !== 5 || d_flt !== 0) begin failures++; $display("FAIL ld_x0: got rdwe %0d cycle %0d fault %0d expected 0/5/0", d_rdwe, d_cyc, d_flt); end
      @(negedge clk);
      run_op(LD_X6_16, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 0, 0, 64'hCAFE, 0, 0);
      checks++; if (d_addr !== 64'h8) begin failures++; $display("FAIL addr_wrap: got %0h expected 8", d_addr); end
      checks++; if (d_rdaddr !== 5'd6 || d_rdata !== 64'hCAFE) begin failures++; $display("FAIL wrap_writeback: got x%0d=%0h expected x6=cafe", d_rdaddr, d_rdata); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      run_op(SD_X2_M8, 64'h100, 64'hAA, 0, -1, 64'h0, 1, 0);
      checks++; if (d_cyc !== 3 || d_req !== 1 || d_flt !== 0 || d_addr !== 64'hF8) begin failures++; $display("FAIL held_start: got cycle %0d req %0d fault %0d addr %0h expected 3/1/0/f8", d_cyc, d_req, d_flt, d_addr); end
      run_op(LD_X5_8, 64'h40, 64'h0, 0, 0, 64'h99, 0, 0);
      checks++; if (d_cyc !== 6 || d_rdata !== 64'h99 || d_addr !== 64'h48) begin failures++; $display("FAIL b2b_ld: got cycle %0d data %0h addr %0h expected 6/99/48", d_cyc, d_rdata, d_addr); end
   endtask

   task automatic test_misalign();
      @(negedge clk);
      run_op(LD_X7_3, 64'h1000, 64'h0, 0, 0, 64'h5, 0, 0);
`ifdef LDST_MISALIGN_TRAP_EN
      checks++; if (d_cyc !== 2 || d_flt !== 1 || d_req !== 0) begin failures++; $display("FAIL misalign_trap: got cycle %0d fault %0d req %0d expected 2/1/0", d_cyc, d_flt, d_req); end
`else
      checks++; if (d_addr !== 64'h1003 || d_flt !== 0 || d_cyc !== 5) begin failures++; $display("FAIL misalign_pass: got addr %0h fault %0d cycle %0d expected 1003/0/5", d_addr, d_flt, d_cyc); end
`endif
   endtask

   task automatic test_reset_abort();
      int seen = 0;
      @(negedge clk);
      instruction = LD_X5_8; rs1_val = 64'h1000; start = 1'b1; mem_ready = 1'b1; mem_rvalid = 1'b0;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1 || mem_req !== 0) begin failures++; $display("FAIL abort_in_wait: got busy %0d req %0d expected 1/0", busy, mem_req); end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done, fault, mem_req, mem_we, rd_we} !== 6'b0 || {mem_addr, mem_wdata, rd_addr, rd_data} !== '0) begin
         failures++; $display("FAIL abort_outputs: ctrl %b addr %0h rd %0d expected all 0", {busy, done, fault, mem_req, mem_we, rd_we}, mem_addr, rd_addr);
      end
      reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1;
      repeat (6) begin
         @(negedge clk);
         if (done || rd_we || busy) seen++;
      end
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      checks++; if (seen !== 0) begin failures++; $display("FAIL abort_quiet: got %0d active cycles expected 0", seen); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; instruction = '0; rs1_val = '0; rs2_val = '0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b0;
      test_ld_basic();
      test_sd_delayed();
      test_illegal();
      test_timeout();
      test_x0_and_wrap();
      test_back_to_back();
      test_misalign();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
